// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment
// display. One digit is driven at a time: CODE carries that digit's nibble to
// the shared hex-to-7-segment decoder and AN pulls that digit's anode low.
// New display words arrive through a valid/ack style load port. They are
// held in a pending register and only copied into the display register at a
// frame boundary, so a half-updated word is never shown. After every digit
// change all anodes are held off for GUARD cycles to suppress ghosting.
//
// Parameters
//   NDIG   number of digits (2..8)
//   DIV    clock cycles per digit slot (>= GUARD+1)
//   GUARD  dead-time cycles with all anodes off after each digit change
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous reset, active-high
//   LD     load request (pulse or level)
//   D      display nibbles, D[3:0] is digit 0 (rightmost)
//   BLK    per-digit blank mask captured with LD, 1 = digit dark
//   LZB    leading-zero blanking enable captured with LD
//   CODE   registered nibble for the digit currently selected
//   AN     anode enables, active-low, at most one bit low
//   FRAME  one-cycle pulse in the cycle the scan returns to digit 0
//   ACK    one-cycle pulse when the pending load has been applied
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int NDIG  = 4,
   parameter int DIV   = 50000,
   parameter int GUARD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LD,
   input  logic [4*NDIG-1:0] D,
   input  logic [NDIG-1:0]   BLK,
   input  logic              LZB,
   output logic [3:0]        CODE,
   output logic [NDIG-1:0]   AN,
   output logic              FRAME,
   output logic              ACK
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW = $clog2(NDIG);
   localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

   // Scan position and dead-time state
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_next;
   logic [GW-1:0] guard;

   // Display register (what is being scanned out)
   logic [NDIG-1:0][3:0] disp_nib;
   logic [NDIG-1:0]      disp_blk;
   logic                 disp_lzb;

   // Next value of the display register, including a load applied this cycle
   logic [NDIG-1:0][3:0] disp_nib_next;
   logic [NDIG-1:0]      disp_blk_next;
   logic                 disp_lzb_next;

   // Pending register holding the most recent load not yet displayed
   logic [NDIG-1:0][3:0] pend_nib;
   logic [NDIG-1:0]      pend_blk;
   logic                 pend_lzb;
   logic                 pend;

   logic tick;
   logic wrap;
   logic boundary;
   logic apply;

   logic [NDIG-1:0] lz;
   logic [NDIG-1:0] dark;

   // A digit slot ends when the prescaler reaches its last count; the frame
   // ends when that happens on the most significant digit.
   assign tick     = (cnt == CW'(DIV - 1));
   assign wrap     = (idx == IW'(NDIG - 1));
   assign boundary = tick && wrap;
   assign apply    = boundary && (LD || pend);

   // Digit index for the next cycle; wraps to digit 0 at the frame boundary.
   always_comb begin
      idx_next = idx;
      if (tick) begin
         if (wrap) begin
            idx_next = '0;
         end else begin
            idx_next = idx + 1'b1;
         end
      end
   end

   // Display contents after this clock edge. A load arriving exactly on the
   // boundary goes straight to the display and takes priority over whatever
   // is pending, since it is the most recent write.
   always_comb begin
      disp_nib_next = disp_nib;
      disp_blk_next = disp_blk;
      disp_lzb_next = disp_lzb;
      if (boundary && LD) begin
         disp_nib_next = D;
         disp_blk_next = BLK;
         disp_lzb_next = LZB;
      end else if (boundary && pend) begin
         disp_nib_next = pend_nib;
         disp_blk_next = pend_blk;
         disp_lzb_next = pend_lzb;
      end
   end

   // Leading-zero blanking: walk from the most significant digit downwards
   // while every nibble seen so far is zero. Digit 0 is always kept so that
   // a value of zero still shows a single "0".
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz       = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_nib[i] == 4'h0);
         lz[i]    = disp_lzb && (i != 0) && zero_run;
      end
   end

   assign dark = disp_blk | lz;

   // Anode drive: everything off during the dead time, otherwise only the
   // selected digit, and only if it is not blanked.
   always_comb begin
      AN = '1;
      if ((guard == '0) && !dark[idx]) begin
         AN[idx] = 1'b0;
      end
   end

   // Prescaler, digit index, dead-time counter and the registered decoder
   // code. CODE is taken from the post-load display contents so that digit 0
   // already shows a freshly applied word in the slot right after the frame
   // boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         guard <= GW'(GUARD);
         CODE  <= 4'h0;
      end else begin
         if (tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         idx  <= idx_next;
         CODE <= disp_nib_next[idx_next];
         if (tick) begin
            guard <= GW'(GUARD);
         end else if (guard != '0) begin
            guard <= guard - 1'b1;
         end
      end
   end

   // Load path: loads between boundaries overwrite the pending register
   // (last write wins); at the boundary the pending word, or a coincident
   // load, is moved into the display and a single ACK follows.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_nib <= '0;
         disp_blk <= '1;
         disp_lzb <= 1'b0;
         pend_nib <= '0;
         pend_blk <= '1;
         pend_lzb <= 1'b0;
         pend     <= 1'b0;
         FRAME    <= 1'b0;
         ACK      <= 1'b0;
      end else begin
         disp_nib <= disp_nib_next;
         disp_blk <= disp_blk_next;
         disp_lzb <= disp_lzb_next;
         FRAME    <= boundary;
         ACK      <= apply;
         if (boundary) begin
            pend <= 1'b0;
         end else if (LD) begin
            pend     <= 1'b1;
            pend_nib <= D;
            pend_blk <= BLK;
            pend_lzb <= LZB;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// Self-checking bench for seg_scan_ctrl with NDIG=4, DIV=4, GUARD=1, so a
// frame lasts 16 cycles and each digit is lit for 3 of its 4 cycles.
// Outputs are sampled on the falling clock edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

   localparam int NDIG  = 4;
   localparam int DIV   = 4;
   localparam int GUARD = 1;

   logic        clk;
   logic        rst;
   logic        ld;
   logic [15:0] d;
   logic [3:0]  blk;
   logic        lzb;
   logic [3:0]  code;
   logic [3:0]  an;
   logic        frame;
   logic        ack;

   int num_checks;
   int num_fails;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  blk;
      logic        lzb;
      logic [15:0] exp_code;
      logic [15:0] exp_an;
   } vec_t;

   vec_t vecs [6];

   seg_scan_ctrl #(
      .NDIG  (NDIG),
      .DIV   (DIV),
      .GUARD (GUARD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .LD    (ld),
      .D     (d),
      .BLK   (blk),
      .LZB   (lzb),
      .CODE  (code),
      .AN    (an),
      .FRAME (frame),
      .ACK   (ack)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and return at the following falling edge
   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Compare one observed value against its expected value
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      num_checks++;
      if (act !== exp) begin
         num_fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Present a one-cycle load request
   task automatic applyStimulus(input logic [15:0] nd, input logic [3:0] nb, input logic nl);
      ld  = 1'b1;
      d   = nd;
      blk = nb;
      lzb = nl;
      stepCycle();
      ld  = 1'b0;
   endtask

   // Wait (bounded) until ACK is seen at a falling edge
   task automatic waitAck();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ack === 1'b1) begin
            seen = 1'b1;
            break;
         end
         stepCycle();
      end
      checkOutput("ack_arrives", {15'd0, seen}, 16'd1);
   endtask

   // Starting in the ACK cycle, check one full frame of CODE and AN.
   // The first cycle of every slot is dead time.
   task automatic checkFrame(input logic [15:0] exp_code, input logic [15:0] exp_an);
      logic [3:0] a;
      checkOutput("ack_pulse", {15'd0, ack}, 16'd1);
      checkOutput("frame_with_ack", {15'd0, frame}, 16'd1);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            a = (c == 0) ? 4'hF : exp_an[4*s +: 4];
            checkOutput("frame_code", {12'd0, code}, {12'd0, exp_code[4*s +: 4]});
            checkOutput("frame_an", {12'd0, an}, {12'd0, a});
            if (s != 0 || c != 0) begin
               checkOutput("single_ack", {15'd0, ack}, 16'd0);
            end
            stepCycle();
         end
      end
   endtask

   initial begin
      num_checks = 0;
      num_fails  = 0;
      rst = 1'b1;
      ld  = 1'b0;
      d   = 16'h0;
      blk = 4'h0;
      lzb = 1'b0;

      vecs[0] = '{d: 16'h12A7, blk: 4'b0000, lzb: 1'b0, exp_code: 16'h12A7, exp_an: 16'h7BDE};
      vecs[1] = '{d: 16'h0050, blk: 4'b0000, lzb: 1'b1, exp_code: 16'h0050, exp_an: 16'hFFDE};
      vecs[2] = '{d: 16'h0000, blk: 4'b0000, lzb: 1'b1, exp_code: 16'h0000, exp_an: 16'hFFFE};
      vecs[3] = '{d: 16'h4321, blk: 4'b0101, lzb: 1'b0, exp_code: 16'h4321, exp_an: 16'h7FDF};
      vecs[4] = '{d: 16'h0102, blk: 4'b0000, lzb: 1'b1, exp_code: 16'h0102, exp_an: 16'hFBDE};
      vecs[5] = '{d: 16'h0800, blk: 4'b0010, lzb: 1'b1, exp_code: 16'h0800, exp_an: 16'hFBFE};

      @(negedge clk);
      stepCycle();
      stepCycle();
      checkOutput("reset_an", {12'd0, an}, 16'h000F);
      checkOutput("reset_code", {12'd0, code}, 16'h0000);
      checkOutput("reset_frame", {15'd0, frame}, 16'd0);
      checkOutput("reset_ack", {15'd0, ack}, 16'd0);
      rst = 1'b0;

      // Dark display after reset; FRAME every 16 cycles
      for (int k = 1; k <= 40; k++) begin
         stepCycle();
         checkOutput("dark_an", {12'd0, an}, 16'h000F);
         checkOutput("dark_code", {12'd0, code}, 16'h0000);
         checkOutput("dark_ack", {15'd0, ack}, 16'd0);
         checkOutput("dark_frame", {15'd0, frame}, {15'd0, (k % 16) == 0});
      end

      // Table-driven loads, each checked over the frame after its ACK
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].d, vecs[v].blk, vecs[v].lzb);
         waitAck();
         checkFrame(vecs[v].exp_code, vecs[v].exp_an);
      end

      // Two loads before one wrap: last write wins, a single ACK
      applyStimulus(16'h1111, 4'h0, 1'b0);
      stepCycle();
      stepCycle();
      applyStimulus(16'h2222, 4'h0, 1'b0);
      waitAck();
      checkFrame(16'h2222, 16'h7BDE);

      // Load exactly on the frame-boundary tick bypasses pending
      for (int i = 0; i < 15; i++) begin
         stepCycle();
      end
      checkOutput("pre_boundary_frame", {15'd0, frame}, 16'd0);
      applyStimulus(16'h3333, 4'h0, 1'b0);
      checkOutput("bypass_ack", {15'd0, ack}, 16'd1);
      checkOutput("bypass_frame", {15'd0, frame}, 16'd1);
      checkOutput("bypass_code", {12'd0, code}, 16'h0003);
      checkOutput("bypass_guard_an", {12'd0, an}, 16'h000F);
      stepCycle();
      checkOutput("bypass_lit_an", {12'd0, an}, 16'h000E);
      checkOutput("bypass_lit_code", {12'd0, code}, 16'h0003);
      for (int i = 0; i < 16; i++) begin
         checkOutput("bypass_no_ack", {15'd0, ack}, 16'd0);
         stepCycle();
      end

      // Reset while a load is pending and a digit is lit
      applyStimulus(16'h5678, 4'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         stepCycle();
      end
      checkOutput("pre_reset_lit", {12'd0, an}, 16'h000D);
      rst = 1'b1;
      stepCycle();
      checkOutput("mid_reset_an", {12'd0, an}, 16'h000F);
      checkOutput("mid_reset_code", {12'd0, code}, 16'h0000);
      checkOutput("mid_reset_ack", {15'd0, ack}, 16'd0);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         stepCycle();
         checkOutput("post_reset_an", {12'd0, an}, 16'h000F);
         checkOutput("post_reset_ack", {15'd0, ack}, 16'd0);
         checkOutput("post_reset_code", {12'd0, code}, 16'h0000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
